frame_dump_tx: RTL

//  Reader side of the destination pixel RAM that the pixel processor fills.
//  On start, it walks addresses 0..NUM_WORDS-1 of a meminferida instance (sync read, 1-cycle latency).

---
 rtl/frame_dump_tx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/frame_dump_tx.sv
// frame_dump_tx: streams a pixel RAM out over UART 8N1.
// Three bytes per 24-bit word, MSB byte first.
module frame_dump_tx #(
  parameter int ADDR_BITS    = 10,
  parameter int RAM_WIDTH    = 24,
  parameter int NUM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [RAM_WIDTH-1:0] mem_do,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST =
    ADDR_BITS'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP,
    S_FIN
  } state_t;

  state_t                 state, state_nxt;
  logic [BW-1:0]          baud, baud_nxt;
  logic [2:0]             bit_idx, bit_nxt;
  logic [1:0]             byte_idx, byte_nxt;
  logic [ADDR_BITS-1:0]   addr_nxt;
  logic [RAM_WIDTH-1:0]   word, word_nxt;
  logic [7:0]             shift, shift_nxt;
  logic [7:0]             byte_sel;
  logic                   tx_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;
  logic                   tick;

  assign tick = (baud == BAUD_LAST);

  // Pick the byte of the latched word for the current slot.
  always_comb begin
    byte_sel = word[7:0];
    unique case (1'b1)
      (byte_idx == 2'd0): byte_sel = word[23:16];
      (byte_idx == 2'd1): byte_sel = word[15:8];
      default:            byte_sel = word[7:0];
    endcase
  end

  // Next-state logic; every output is registered from here.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    addr_nxt  = mem_addr;
    word_nxt  = word;
    shift_nxt = shift;
    tx_nxt    = 1'b1;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ADDR;
          addr_nxt  = '0;
          busy_nxt  = 1'b1;
        end
      end
      S_ADDR: begin
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        word_nxt  = mem_do;
        byte_nxt  = 2'd0;
        baud_nxt  = '0;
        state_nxt = S_START;
      end
      S_START: begin
        tx_nxt    = 1'b0;
        shift_nxt = byte_sel;
        if (tick) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          state_nxt = S_DATA;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      S_DATA: begin
        tx_nxt = shift[0];
        if (tick) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            bit_nxt = bit_idx + 1'b1;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          baud_nxt = '0;
          if (byte_idx < 2'd2) begin
            byte_nxt  = byte_idx + 1'b1;
            state_nxt = S_START;
          end else if (mem_addr == ADDR_LAST) begin
            state_nxt = S_FIN;
          end else begin
            addr_nxt  = mem_addr + 1'b1;
            state_nxt = S_ADDR;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      S_FIN: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      mem_addr <= '0;
      word     <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud     <= baud_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      mem_addr <= addr_nxt;
      word     <= word_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule
